// File: rtl/shift_sequencer.sv
// Sequences an external 32-bit shift/load register through load, N single-bit
// right shifts and a capture, giving logical, arithmetic or rotate right shifts.
module shift_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] data_in,
   input  logic [4:0]  amount,
   input  logic [1:0]  mode,
   input  logic [31:0] reg_state,
   output logic [31:0] reg_load,
   output logic        reg_sel,
   output logic        reg_shiftin,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [4:0]  cnt;
   logic [31:0] data_q;
   logic [4:0]  amount_q;
   logic [1:0]  mode_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Outside LOAD/SHIFT the register is fed its own value so it simply holds.
   always_comb begin
      next_state  = state;
      reg_sel     = 1'b1;
      reg_load    = reg_state;
      reg_shiftin = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            reg_load   = data_q;
            next_state = (cnt != 5'd0) ? SHIFT : CAPTURE;
         end
         SHIFT: begin
            reg_sel  = 1'b0;
            reg_load = data_q;
            case (mode_q)
               2'b01:   reg_shiftin = reg_state[31];
               2'b10:   reg_shiftin = reg_state[0];
               default: reg_shiftin = 1'b0;
            endcase
            if (cnt == 5'd1) begin
               next_state = CAPTURE;
            end
         end
         CAPTURE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= 5'd0;
         data_q   <= 32'd0;
         amount_q <= 5'd0;
         mode_q   <= 2'd0;
         result   <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= (state == CAPTURE);
         if (state == IDLE && start) begin
            data_q   <= data_in;
            amount_q <= amount;
            mode_q   <= mode;
            cnt      <= amount;
         end else if (state == SHIFT) begin
            cnt <= cnt - 5'd1;
         end
         if (state == CAPTURE) begin
            result <= reg_state;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
